fifo_sync_pgen: RTL and testbench

Parametrised single-clock FIFO with a built-in pattern generator for board bring-up and link soak tests.
- Adds over the previous-generation buffer: all DEPTH entries usable, selectable first-word-fall-through (FWFT) or registered read, occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags.
- Pattern generator is a run-time-enabled source with two modes: incrementing count or 32-bit LFSR.
- Sits between a producer (or the generator) and a UART/debug drain in the demo SoC.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_sync_pgen_pgen_src.sv | 76 +++++++
 rtl/fifo_sync_pgen.sv | 120 ++++++++++++
 tb/tb_fifo_sync_pgen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the pattern-generating synchronous FIFO.
package fifo_pkg;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  // Taps 32,22,2,1 as bit indices 31,21,1,0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    PG_IDLE = 2'd0,
    PG_WAIT = 2'd1,
    PG_RUN  = 2'd2
  } pg_state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_pgen_pgen_src.sv
// Pattern source: waits PGEN_DELAY cycles after enable, then offers count or LFSR words.
module pgen_src
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int PGEN_DELAY = 16384
) (
  input  logic             iclk,
  input  logic             irstn,
  input  logic             en,
  input  logic             mode,
  input  logic             accept,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output pg_state_e        state
);

  localparam int DW = $clog2(PGEN_DELAY + 1);

  logic [DW-1:0]    delay_cnt;
  logic             mode_q;
  logic [WIDTH-1:0] inc_val;
  logic [31:0]      lfsr;
  logic [WIDTH-1:0] lfsr_ext;

  generate
    if (WIDTH >= 32) begin : g_ext
      assign lfsr_ext = {{(WIDTH - 32){1'b0}}, lfsr};
    end else begin : g_trunc
      assign lfsr_ext = lfsr[WIDTH-1:0];
    end
  endgenerate

  // Handshake: a word is offered while valid; it is consumed, and the pattern
  // advances, only in a cycle where valid && accept. Without accept it holds.
  assign valid = (state == PG_RUN) && en;
  assign data  = mode_q ? lfsr_ext : inc_val;

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      state     <= PG_IDLE;
      delay_cnt <= '0;
      mode_q    <= 1'b0;
      inc_val   <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      case (state)
        PG_IDLE: begin
          delay_cnt <= '0;
          inc_val   <= '0;
          lfsr      <= LFSR_SEED;
          mode_q    <= mode;
          if (en) state <= PG_WAIT;
        end
        PG_WAIT: begin
          if (!en) begin
            state <= PG_IDLE;
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
            if (delay_cnt == DW'(PGEN_DELAY - 1)) state <= PG_RUN;
          end
        end
        PG_RUN: begin
          if (!en) begin
            state <= PG_IDLE;
          end else if (accept) begin
            if (mode_q) lfsr <= {lfsr[30:0], ^(lfsr & LFSR_TAPS)};
            else        inc_val <= inc_val + 1'b1;
          end
        end
        default: state <= PG_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_sync_pgen.sv
// Single-clock FIFO with occupancy flags, sticky error flags and an optional
// built-in pattern source that writes when no external write is requested.
module fifo_sync_pgen
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 64,
  parameter bit FWFT       = 1'b0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int PGEN_DELAY = 16384
) (
  input  logic                        iclk,
  input  logic                        irstn,
  input  logic                        iwren,
  input  logic [WIDTH-1:0]            din,
  input  logic                        irden,
  output logic [WIDTH-1:0]            dout,
  output logic                        ovalid,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        ovf,
  output logic                        udf,
  input  logic                        iclr_err,
  input  logic                        ipgen_en,
  input  logic                        ipgen_mode,
  output logic [1:0]                  pgen_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  logic             pg_valid;
  logic [WIDTH-1:0] pg_data;
  logic             pg_accept;
  pg_state_e        pg_state;

  logic             wr_src;
  logic [WIDTH-1:0] wr_data;
  logic             wr_acc;
  logic             rd_acc;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  assign wr_src    = iwren | pg_valid;
  assign wr_data   = iwren ? din : pg_data;
  assign wr_acc    = wr_src & ~full;
  assign rd_acc    = irden & ~empty;
  assign pg_accept = ~iwren & pg_valid & ~full;
  assign pgen_state = pg_state;

  pgen_src #(
    .WIDTH      (WIDTH),
    .PGEN_DELAY (PGEN_DELAY)
  ) u_pgen (
    .iclk   (iclk),
    .irstn  (irstn),
    .en     (ipgen_en),
    .mode   (ipgen_mode),
    .accept (pg_accept),
    .valid  (pg_valid),
    .data   (pg_data),
    .state  (pg_state)
  );

  always_ff @(posedge iclk) begin
    if (wr_acc) mem[wptr] <= wr_data;
  end

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (iclr_err)           ovf <= 1'b0;
      else if (iwren && full) ovf <= 1'b1;
      // A read at empty that coincides with an accepted write is not an underflow
      if (iclr_err)                           udf <= 1'b0;
      else if (irden && empty && !wr_acc)     udf <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout   = mem[rptr];
      assign ovalid = ~empty;
    end else begin : g_reg
      always_ff @(posedge iclk) begin
        if (!irstn) begin
          dout   <= '0;
          ovalid <= 1'b0;
        end else begin
          ovalid <= rd_acc;
          if (rd_acc) dout <= mem[rptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_pgen.sv
// Randomised bench for fifo_sync_pgen against a queue-based reference model.
module tb_fifo_sync_pgen;

  localparam int DEPTH = 16;
  localparam int WIDTH = 64;
  localparam int PGEN_DELAY = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b0;
  logic wren = 1'b0, rden = 1'b0, clr_err = 1'b0, pg_en = 1'b0, pg_mode = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic ovalid, empty, full, afull, aempty, ovf, udf;
  logic [4:0] count;
  logic [1:0] pg_state;

  logic f_wren = 1'b0, f_rden = 1'b0;
  logic [WIDTH-1:0] f_din = '0;
  logic [WIDTH-1:0] f_dout;
  logic f_ovalid, f_empty, f_full, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] f_count;
  logic [1:0] f_pg_state;

  fifo_sync_pgen #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1'b0), .PGEN_DELAY(PGEN_DELAY)) dut (
    .iclk(clk), .irstn(rstn), .iwren(wren), .din(din), .irden(rden), .dout(dout),
    .ovalid(ovalid), .empty(empty), .full(full), .almost_full(afull), .almost_empty(aempty),
    .count(count), .ovf(ovf), .udf(udf), .iclr_err(clr_err), .ipgen_en(pg_en),
    .ipgen_mode(pg_mode), .pgen_state(pg_state));

  fifo_sync_pgen #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1'b1), .PGEN_DELAY(PGEN_DELAY)) dut_fwft (
    .iclk(clk), .irstn(rstn), .iwren(f_wren), .din(f_din), .irden(f_rden), .dout(f_dout),
    .ovalid(f_ovalid), .empty(f_empty), .full(f_full), .almost_full(f_afull),
    .almost_empty(f_aempty), .count(f_count), .ovf(f_ovf), .udf(f_udf), .iclr_err(1'b0),
    .ipgen_en(1'b0), .ipgen_mode(1'b0), .pgen_state(f_pg_state));

  // Reference model state
  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf, m_udf, m_ovalid;
  logic [WIDTH-1:0] m_dout;
  int               streak;
  logic             g_mode;
  logic [WIDTH-1:0] g_inc;
  logic [31:0]      g_lfsr;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    logic fb;
    fb = l[31] ^ l[21] ^ l[1] ^ l[0];
    return (l << 1) | {31'b0, fb};
  endfunction

  // Drive one cycle of DUT inputs, advance the model, and step past the edge.
  task automatic cycle(input logic wr, input logic [WIDTH-1:0] d, input logic rd, input logic clr);
    logic offer, src, wacc, racc;
    logic [WIDTH-1:0] wdata;
    wren = wr; din = d; rden = rd; clr_err = clr;
    if (!rstn) begin
      exp_q.delete();
      m_ovf = 0; m_udf = 0; m_ovalid = 0; m_dout = '0;
      streak = 0; g_mode = 0; g_inc = '0; g_lfsr = 32'h1;
    end else begin
      offer = pg_en && (streak >= PGEN_DELAY + 1);
      src   = wr || offer;
      wdata = wr ? d : (g_mode ? {32'h0, g_lfsr} : g_inc);
      wacc  = src && (exp_q.size() < DEPTH);
      racc  = rd && (exp_q.size() > 0);
      if (clr) m_ovf = 0;
      else if (wr && exp_q.size() == DEPTH) m_ovf = 1;
      if (clr) m_udf = 0;
      else if (rd && exp_q.size() == 0 && !wacc) m_udf = 1;
      m_ovalid = racc;
      if (racc) m_dout = exp_q.pop_front();
      if (wacc) exp_q.push_back(wdata);
      if (wacc && !wr) begin
        if (g_mode) g_lfsr = lfsr_next(g_lfsr);
        else g_inc = g_inc + 1;
      end
      if (streak == 0) begin
        g_inc = '0; g_lfsr = 32'h1; g_mode = pg_mode;
      end
      streak = pg_en ? streak + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; pg_en = 0; pg_mode = 0; f_wren = 0; f_rden = 0;
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
    n_vec++; if (aempty !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b exp 1", aempty); end
    n_vec++; if (afull !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b exp 0", afull); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout got %h exp 0", dout); end
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid got %b exp 0", ovalid); end
    n_vec++; if ({ovf, udf} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b exp 00", {ovf, udf}); end
    n_vec++; if (pg_state !== 2'd0) begin n_err++; $display("FAIL reset_pgstate got %0d exp 0", pg_state); end
    n_vec++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL reset_fwft_empty got %b exp 1", f_empty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, WIDTH'(i), 0, 0);
      n_vec++; if (int'(count) != i + 1) begin n_err++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
      n_vec++; if (afull !== (i + 1 >= DEPTH - 2)) begin n_err++; $display("FAIL fill_afull got %b at count %0d", afull, i + 1); end
      n_vec++; if (aempty !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_aempty got %b at count %0d", aempty, i + 1); end
      n_vec++; if (full !== (i + 1 == DEPTH)) begin n_err++; $display("FAIL fill_full got %b at count %0d", full, i + 1); end
    end
    cycle(1, 64'h99, 0, 0);
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL overflow_flag got %b exp 1", ovf); end
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL overflow_count got %0d exp 16", count); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, '0, 1, 0);
      n_vec++; if (ovalid !== 1'b1) begin n_err++; $display("FAIL drain_ovalid got %b exp 1", ovalid); end
      n_vec++; if (dout !== WIDTH'(i)) begin n_err++; $display("FAIL drain_data got %h exp %h", dout, WIDTH'(i)); end
    end
    cycle(0, '0, 0, 0);
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL idle_ovalid got %b exp 0", ovalid); end
    n_vec++; if (dout !== 64'hF) begin n_err++; $display("FAIL hold_dout got %h exp f", dout); end
    cycle(0, '0, 0, 1);
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", ovf); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cycle(1, {$urandom, $urandom}, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, {$urandom, $urandom}, 1, 0);
      n_vec++; if (count !== 5'd5) begin n_err++; $display("FAIL b2b_count got %0d exp 5", count); end
      n_vec++; if (dout !== m_dout || ovalid !== 1'b1) begin n_err++; $display("FAIL b2b_data got %h/%b exp %h/1", dout, ovalid, m_dout); end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 1, 0);
      n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL b2b_drain got %h exp %h", dout, m_dout); end
    end
    cycle(1, 64'h5A5A, 1, 0);
    n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL empty_rw_count got %0d exp 1", count); end
    n_vec++; if (udf !== 1'b0) begin n_err++; $display("FAIL empty_rw_udf got %b exp 0", udf); end
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL empty_rw_ovalid got %b exp 0", ovalid); end
    cycle(0, '0, 1, 0);
    n_vec++; if (dout !== 64'h5A5A) begin n_err++; $display("FAIL empty_rw_data got %h exp 5a5a", dout); end
    cycle(0, '0, 1, 0);
    n_vec++; if (udf !== 1'b1) begin n_err++; $display("FAIL underflow got %b exp 1", udf); end
    cycle(0, '0, 0, 1);
    n_vec++; if (udf !== 1'b0) begin n_err++; $display("FAIL udf_clear got %b exp 0", udf); end
  endtask

  task automatic test_fwft();
    f_din = 64'hAB; f_wren = 1;
    cycle(0, '0, 0, 0);
    f_wren = 0;
    n_vec++; if (f_dout !== 64'hAB) begin n_err++; $display("FAIL fwft_dout got %h exp ab", f_dout); end
    n_vec++; if (f_ovalid !== 1'b1) begin n_err++; $display("FAIL fwft_ovalid got %b exp 1", f_ovalid); end
    f_rden = 1;
    cycle(0, '0, 0, 0);
    f_rden = 0;
    n_vec++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL fwft_pop_empty got %b exp 1", f_empty); end
    n_vec++; if (f_ovalid !== 1'b0) begin n_err++; $display("FAIL fwft_pop_ovalid got %b exp 0", f_ovalid); end
  endtask

  task automatic test_pgen_inc();
    do_reset();
    pg_mode = 0; pg_en = 1;
    for (int i = 0; i < 30; i++) begin
      cycle(0, '0, 0, 0);
      n_vec++; if (int'(count) != exp_q.size()) begin n_err++; $display("FAIL pginc_count got %0d exp %0d", count, exp_q.size()); end
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL pginc_ovf got %b exp 0", ovf); end
    end
    for (int i = 0; i < 32; i++) begin
      cycle(0, '0, 1, 0);
      n_vec++; if (dout !== WIDTH'(i) || dout !== m_dout) begin n_err++; $display("FAIL pginc_data got %h exp %h", dout, WIDTH'(i)); end
    end
    pg_en = 0;
    cycle(0, '0, 0, 0);
    n_vec++; if (pg_state !== 2'd0) begin n_err++; $display("FAIL pginc_idle got %0d exp 0", pg_state); end
  endtask

  task automatic test_pgen_lfsr();
    int nrd;
    do_reset();
    pg_mode = 1; pg_en = 1; nrd = 0;
    for (int i = 0; i < PGEN_DELAY + 1010; i++) begin
      if (i == 500) pg_mode = 0;
      cycle(0, '0, 1, 0);
      n_vec++; if (ovalid !== m_ovalid) begin n_err++; $display("FAIL lfsr_ovalid got %b exp %b", ovalid, m_ovalid); end
      if (m_ovalid) begin
        n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL lfsr_data got %h exp %h", dout, m_dout); end
        if (nrd == 0) begin
          n_vec++; if (dout !== 64'h1) begin n_err++; $display("FAIL lfsr_first got %h exp 1", dout); end
        end
        nrd++;
      end
    end
    n_vec++; if (nrd < 1000) begin n_err++; $display("FAIL lfsr_reads got %0d exp >=1000", nrd); end
    pg_mode = 1; pg_en = 0;
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    n_vec++; if (pg_state !== 2'd0) begin n_err++; $display("FAIL lfsr_idle got %0d exp 0", pg_state); end
    pg_en = 1; nrd = 0;
    for (int i = 0; i < PGEN_DELAY + 5; i++) begin
      cycle(0, '0, 1, 0);
      if (m_ovalid && nrd == 0) begin
        n_vec++; if (dout !== 64'h1) begin n_err++; $display("FAIL lfsr_restart got %h exp 1", dout); end
        nrd++;
      end
    end
    pg_en = 0;
    cycle(0, '0, 0, 1);
  endtask

  task automatic test_random_wrap();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0);
      n_vec++; if (int'(count) != exp_q.size()) begin n_err++; $display("FAIL wrap_count got %0d exp %0d", count, exp_q.size()); end
      n_vec++; if (ovalid !== m_ovalid) begin n_err++; $display("FAIL wrap_ovalid got %b exp %b", ovalid, m_ovalid); end
      if (m_ovalid) begin
        n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL wrap_data got %h exp %h", dout, m_dout); end
      end
      n_vec++; if ({ovf, udf} !== {m_ovf, m_udf}) begin n_err++; $display("FAIL wrap_err got %b exp %b", {ovf, udf}, {m_ovf, m_udf}); end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) cycle(1, {$urandom, $urandom}, 0, 0);
    rstn = 1'b0;
    cycle(1, 64'h77, 0, 0);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL midreset_empty got %b exp 1", empty); end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL midreset_count got %0d exp 0", count); end
    rstn = 1'b1;
    cycle(0, '0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_fwft();
    test_pgen_inc();
    test_pgen_lfsr();
    test_random_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
